pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central hazard and stall controller for the 5-stage pipeline. It decides each cycle whether PC, IF_ID, ID_EX, EX_MEM and MEM_WB advance, hold, flush or take a bubble. It covers three cases: load-use hazards, taken-branch flushes resolved in ID, and multi-cycle data-memory accesses. Memory accesses use a handshake and a timeout watchdog. The ID_EX bubble encoding is `CTRL_BUBBLE` (4'b1111).

## Interface
Parameters:
- `MEM_TIMEOUT`, default 64: maximum MEM_WAIT cycles before abort; legal range 1..255.

Ports:
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset; synchronous, active-high.
- `if_id_rs1_i`, `if_id_rs2_i` in 5 each: source registers of the instruction in ID.
- `id_ex_rd_i` in 5: destination register of the instruction in EX.
- `id_ex_memread_i` in 1: the instruction in EX is a load.
- `branch_taken_i` in 1: ID resolved a taken branch or jump this cycle.
- `mem_req_i` in 1: MEM stage is issuing a data-memory access this cycle.
- `mem_ready_i` in 1: data memory completes the access this cycle.
- `pc_write_o` out 1: PC update enable.
- `if_id_write_o` out 1: IF_ID enable.
- `if_id_flush_o` out 1: IF_ID loads a NOP.
- `id_ex_hazard_o` out 1: ID_EX loads `CTRL_BUBBLE` instead of the ID control.
- `id_ex_hold_o`, `ex_mem_hold_o`, `mem_wb_hold_o` out 1 each: stage register keeps its value.
- `mem_abort_o` out 1: one-cycle abort pulse to data memory on timeout.
- `err_o` out 1: sticky timeout flag; cleared only by `rst_i`.
- `stall_cnt_o`, `flush_cnt_o` out 32 each: performance counters.

## Operation
- FSM states:
  - RUN: normal flow; reset state.
  - MEM_WAIT: pipeline frozen on an outstanding memory access.
- `load_use` = `id_ex_memread_i` & (`id_ex_rd_i` != 0) & (`id_ex_rd_i` == `if_id_rs1_i` or `id_ex_rd_i` == `if_id_rs2_i`).
- `freeze`:
  - in RUN: `mem_req_i` & !`mem_ready_i`;
  - in MEM_WAIT: !`mem_ready_i`.
- Priority: freeze > load_use > branch_taken.
- freeze response:
  - `pc_write_o`=0, `if_id_write_o`=0;
  - `id_ex_hold_o`, `ex_mem_hold_o`, `mem_wb_hold_o` all 1;
  - no flush, no bubble.
- load_use response:
  - `pc_write_o`=0, `if_id_write_o`=0;
  - `id_ex_hazard_o`=1;
  - `branch_taken_i` ignored, because ID re-resolves the branch next cycle with forwarded data.
- branch_taken response (no freeze, no load_use): `if_id_flush_o`=1; PC writes the target.
- Otherwise: all enables 1, all holds, flushes and bubbles 0.
- State transitions:
  - RUN → MEM_WAIT when `mem_req_i` & !`mem_ready_i`; the wait counter clears.
  - MEM_WAIT → RUN on `mem_ready_i`; that cycle is unfrozen.
  - MEM_WAIT → RUN on timeout: counter reaches `MEM_TIMEOUT` with !`mem_ready_i`. In that cycle `mem_abort_o`=1 and `err_o` is set; the freeze still holds, and the pipeline releases next cycle.
- Wait counter:
  - 8 bits, cleared on entry to MEM_WAIT;
  - increments each MEM_WAIT cycle without ready;
  - never wraps, because timeout triggers first.
- A zero-wait access (`mem_req_i` & `mem_ready_i` in RUN) causes no stall.

## Timing
- All hazard outputs are combinational from inputs and current state, so they act in the same cycle. Only the state, wait counter, `err_o` and the performance counters are registered.
- While `rst_i`=1, outputs are forced to:
  - `pc_write_o`=0, `if_id_write_o`=0;
  - `if_id_flush_o`=1, `id_ex_hazard_o`=1;
  - all holds 0;
  - `mem_abort_o`=0.
- After reset: state RUN, counter 0, `err_o`=0, both performance counters 0.
- Reset asserted mid-MEM_WAIT: state returns to RUN next edge, with no `mem_abort_o` pulse.
- Load-use costs exactly 1 bubble cycle.
- A taken branch costs 1 flushed fetch.
- A memory wait of N cycles freezes the pipeline N cycles; N ≤ `MEM_TIMEOUT`+1 including the abort cycle.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_cnt_o` increments on each freeze or load_use cycle;
  - `flush_cnt_o` increments on each `if_id_flush_o` cycle outside reset;
  - both saturate at 32'hFFFFFFFF.
- `PIPE_CTRL_PERF_EN` undefined: both ports are tied to 0 and the counter registers are not built.

## Structure
- Shared package `pipe_pkg` holds:
  - `CTRL_BUBBLE` = 4'b1111;
  - FSM state encoding: RUN=1'b0, MEM_WAIT=1'b1;
  - `REG_ZERO` = 5'd0.
- One sub-module, `pipe_perf_cnt`: saturating 32-bit counter with enable. Instantiated twice, only under `PIPE_CTRL_PERF_EN`.

## Test plan
- Load at EX with rd=5, ID reads rs1=5 → one cycle of `pc_write_o`=0, `if_id_write_o`=0, `id_ex_hazard_o`=1; next cycle normal flow. Same case with rd=0 → no stall.
- `branch_taken_i`=1 with no hazard → `if_id_flush_o`=1 for one cycle. `branch_taken_i` together with load_use → bubble only, no flush.
- `mem_req_i`=1 with `mem_ready_i` low for 3 cycles, then high → all holds 1 for 3 cycles; the ready cycle is unfrozen; state back to RUN.
- `mem_ready_i` held low with `MEM_TIMEOUT`=4 → `mem_abort_o` pulses on the 5th frozen cycle; `err_o`=1 and stays set; freeze released next cycle.
- `rst_i` asserted during MEM_WAIT → reset output values for that cycle; RUN afterwards; `err_o`=0; no abort pulse.
- With `PIPE_CTRL_PERF_EN`: 2 load-use stalls plus 3 wait cycles → `stall_cnt_o`=5. Without the macro → both counters read 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_pkg;

  localparam logic [3:0] CTRL_BUBBLE = 4'b1111;
  localparam logic [4:0] REG_ZERO    = 5'd0;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_hazard;
    logic id_ex_hold;
    logic ex_mem_hold;
    logic mem_wb_hold;
    logic mem_abort;
  } ctrl_out_t;

  // Control word the ID_EX register should capture given the hazard decision.
  function automatic logic [3:0] id_ex_ctrl_sel(input logic hazard, input logic [3:0] id_ctrl);
    return hazard ? CTRL_BUBBLE : id_ctrl;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stage-control outputs between the pipeline datapath and pipeline_ctrl.
interface pipeline_ctrl_if;
  logic [4:0]  if_id_rs1_i;
  logic [4:0]  if_id_rs2_i;
  logic [4:0]  id_ex_rd_i;
  logic        id_ex_memread_i;
  logic        branch_taken_i;
  logic        mem_req_i;
  logic        mem_ready_i;
  logic        pc_write_o;
  logic        if_id_write_o;
  logic        if_id_flush_o;
  logic        id_ex_hazard_o;
  logic        id_ex_hold_o;
  logic        ex_mem_hold_o;
  logic        mem_wb_hold_o;
  logic        mem_abort_o;
  logic        err_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

  modport master (
    output if_id_rs1_i, if_id_rs2_i, id_ex_rd_i, id_ex_memread_i,
           branch_taken_i, mem_req_i, mem_ready_i,
    input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_hazard_o,
           id_ex_hold_o, ex_mem_hold_o, mem_wb_hold_o, mem_abort_o,
           err_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  if_id_rs1_i, if_id_rs2_i, id_ex_rd_i, id_ex_memread_i,
           branch_taken_i, mem_req_i, mem_ready_i,
    output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_hazard_o,
           id_ex_hold_o, ex_mem_hold_o, mem_wb_hold_o, mem_abort_o,
           err_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_perf_cnt.sv
// Saturating 32-bit event counter with enable.
module pipe_perf_cnt (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [31:0] cnt_o
);
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use bubbles, branch flushes, memory-wait freeze.
// Optional perf counters built only when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pipeline_ctrl_if.slave bus
);
  // Last legal wait count; reaching it without ready aborts on that cycle.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       err_q, err_d;
  logic       load_use, freeze, timeout;
  ctrl_out_t  ctrl;

  always_comb begin
    load_use = bus.id_ex_memread_i && (bus.id_ex_rd_i != REG_ZERO) &&
               ((bus.id_ex_rd_i == bus.if_id_rs1_i) || (bus.id_ex_rd_i == bus.if_id_rs2_i));
    freeze   = (state_q == MEM_WAIT) ? !bus.mem_ready_i : (bus.mem_req_i && !bus.mem_ready_i);
    timeout  = (state_q == MEM_WAIT) && !bus.mem_ready_i && (wait_cnt_q == WAIT_LAST);
  end

  always_comb begin
    ctrl             = '0;
    ctrl.pc_write    = 1'b1;
    ctrl.if_id_write = 1'b1;
    if (rst_i) begin
      ctrl              = '0;
      ctrl.if_id_flush  = 1'b1;
      ctrl.id_ex_hazard = 1'b1;
    end else if (freeze) begin
      ctrl.pc_write    = 1'b0;
      ctrl.if_id_write = 1'b0;
      ctrl.id_ex_hold  = 1'b1;
      ctrl.ex_mem_hold = 1'b1;
      ctrl.mem_wb_hold = 1'b1;
      ctrl.mem_abort   = timeout;
    end else if (load_use) begin
      // Branch is dropped here; ID re-resolves it next cycle with forwarded data.
      ctrl.pc_write     = 1'b0;
      ctrl.if_id_write  = 1'b0;
      ctrl.id_ex_hazard = 1'b1;
    end else if (bus.branch_taken_i) begin
      ctrl.if_id_flush = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q | timeout;
    case (state_q)
      RUN: if (bus.mem_req_i && !bus.mem_ready_i) begin
        state_d    = MEM_WAIT;
        wait_cnt_d = '0;
      end
      MEM_WAIT: begin
        if (bus.mem_ready_i || timeout) state_d    = RUN;
        else                            wait_cnt_d = wait_cnt_q + 8'd1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign bus.pc_write_o     = ctrl.pc_write;
  assign bus.if_id_write_o  = ctrl.if_id_write;
  assign bus.if_id_flush_o  = ctrl.if_id_flush;
  assign bus.id_ex_hazard_o = ctrl.id_ex_hazard;
  assign bus.id_ex_hold_o   = ctrl.id_ex_hold;
  assign bus.ex_mem_hold_o  = ctrl.ex_mem_hold;
  assign bus.mem_wb_hold_o  = ctrl.mem_wb_hold;
  assign bus.mem_abort_o    = ctrl.mem_abort;
  assign bus.err_o          = err_q;

`ifdef PIPE_CTRL_PERF_EN
  pipe_perf_cnt u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (!rst_i && (freeze || load_use)),
    .cnt_o (bus.stall_cnt_o)
  );

  pipe_perf_cnt u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (!rst_i && ctrl.if_id_flush),
    .cnt_o (bus.flush_cnt_o)
  );
`else
  assign bus.stall_cnt_o = '0;
  assign bus.flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, corner sequences, then random traffic vs a reference model.
module tb_pipeline_ctrl;
  localparam int TMO = 4;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  pipeline_ctrl_if bus();

  pipeline_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: in_wait = access outstanding, nfrz = frozen cycles so far for it.
  bit     m_wait;
  int     m_nfrz;
  bit     m_err;
  longint m_stall, m_flush;

  typedef struct {
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       ld, br, req, rdy;
    logic [7:0] exp;  // {pc_w, ifid_w, flush, hazard, idex_h, exmem_h, memwb_h, abort}
  } vec_t;

  function automatic vec_t mk(logic r, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic ld, logic br, logic req, logic rdy, logic [7:0] exp);
    vec_t v;
    v.rst = r; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.ld = ld; v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  function automatic logic [7:0] dut_out();
    return {bus.pc_write_o, bus.if_id_write_o, bus.if_id_flush_o, bus.id_ex_hazard_o,
            bus.id_ex_hold_o, bus.ex_mem_hold_o, bus.mem_wb_hold_o, bus.mem_abort_o};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input vec_t v, input bit use_exp, input string tag);
    logic lu, frz, abrt;
    logic [7:0] e;
    rst                 = v.rst;
    bus.if_id_rs1_i     = v.rs1;
    bus.if_id_rs2_i     = v.rs2;
    bus.id_ex_rd_i      = v.rd;
    bus.id_ex_memread_i = v.ld;
    bus.branch_taken_i  = v.br;
    bus.mem_req_i       = v.req;
    bus.mem_ready_i     = v.rdy;
    #2;
    lu   = v.ld && (v.rd != 0) && (v.rd == v.rs1 || v.rd == v.rs2);
    frz  = m_wait ? !v.rdy : (v.req && !v.rdy);
    abrt = m_wait && !v.rdy && (m_nfrz == TMO);
    if (v.rst)    e = 8'b0011_0000;
    else if (frz) e = {7'b0000_111, abrt};
    else if (lu)  e = 8'b0001_0000;
    else          e = {2'b11, v.br, 5'b0};
    check({tag, "_model"}, 64'(dut_out()), 64'(e));
    if (use_exp) check({tag, "_vec"}, 64'(dut_out()), 64'(v.exp));
    check({tag, "_err"}, 64'(bus.err_o), 64'(m_err));
    check({tag, "_stall_cnt"}, 64'(bus.stall_cnt_o), PERF ? m_stall : 64'd0);
    check({tag, "_flush_cnt"}, 64'(bus.flush_cnt_o), PERF ? m_flush : 64'd0);
    if (v.rst) begin
      m_wait = 0; m_nfrz = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (m_wait) begin
        if (v.rdy || abrt) begin m_wait = 0; m_nfrz = 0; end
        else m_nfrz++;
      end else if (v.req && !v.rdy) begin
        m_wait = 1; m_nfrz = 1;
      end
      if (abrt) m_err = 1;
      if ((frz || lu) && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (e[5] && m_flush < 64'hFFFF_FFFF) m_flush++;
    end
    @(negedge clk);
  endtask

  localparam logic [7:0] NRM = 8'b1100_0000, BUB = 8'b0001_0000, BRF = 8'b1110_0000;
  localparam logic [7:0] FRZ = 8'b0000_1110, ABT = 8'b0000_1111, RST = 8'b0011_0000;

  vec_t tbl[$];
  vec_t v;

  initial begin
    m_wait = 0; m_nfrz = 0; m_err = 0; m_stall = 0; m_flush = 0;
    rst = 1'b1;
    bus.if_id_rs1_i = '0; bus.if_id_rs2_i = '0; bus.id_ex_rd_i = '0;
    bus.id_ex_memread_i = 0; bus.branch_taken_i = 0; bus.mem_req_i = 0; bus.mem_ready_i = 0;
    @(negedge clk);

    // Single-cycle decisions from RUN
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, RST));
    tbl.push_back(mk(0, 5, 6, 5, 0, 0, 0, 0, NRM));
    tbl.push_back(mk(0, 5, 6, 5, 1, 0, 0, 0, BUB));
    tbl.push_back(mk(0, 1, 2, 5, 0, 0, 0, 0, NRM));
    tbl.push_back(mk(0, 0, 3, 0, 1, 0, 0, 0, NRM));
    tbl.push_back(mk(0, 1, 2, 3, 0, 1, 0, 0, BRF));
    tbl.push_back(mk(0, 1, 7, 7, 1, 1, 0, 0, BUB));
    tbl.push_back(mk(0, 1, 2, 3, 0, 0, 1, 1, NRM));
    tbl.push_back(mk(0, 1, 2, 3, 0, 1, 1, 1, BRF));
    tbl.push_back(mk(1, 4, 4, 4, 1, 1, 1, 0, RST));
    tbl.push_back(mk(0, 9, 8, 7, 1, 0, 0, 0, NRM));
    foreach (tbl[i]) cyc(tbl[i], 1, $sformatf("vec%0d", i));

    // Three wait cycles then ready: ready cycle unfrozen, back in RUN
    for (int i = 0; i < 3; i++) cyc(mk(0, 0, 0, 0, 0, 0, 1, 0, FRZ), 1, "wait3");
    cyc(mk(0, 0, 0, 0, 0, 0, 1, 1, NRM), 1, "wait3_ready");
    cyc(mk(0, 0, 0, 0, 0, 1, 0, 0, BRF), 1, "wait3_after");

    // Timeout: abort on the fifth frozen cycle, err sticky, release next cycle
    for (int i = 0; i < TMO; i++) cyc(mk(0, 0, 0, 0, 0, 0, 1, 0, FRZ), 1, "tmo_frz");
    cyc(mk(0, 0, 0, 0, 0, 0, 1, 0, ABT), 1, "tmo_abort");
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, NRM), 1, "tmo_release");
    check("tmo_err_set", 64'(bus.err_o), 64'd1);
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 1, NRM), 1, "tmo_sticky");

    // Reset during MEM_WAIT: reset outputs, no abort, RUN with err cleared
    for (int i = 0; i < 3; i++) cyc(mk(0, 0, 0, 0, 0, 0, 1, 0, FRZ), 1, "rstw_frz");
    cyc(mk(1, 0, 0, 0, 0, 0, 1, 0, RST), 1, "rstw_rst");
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, NRM), 1, "rstw_run");
    check("rstw_err_clr", 64'(bus.err_o), 64'd0);

    // Perf: two load-use stalls plus three wait cycles
    cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, RST), 1, "perf_rst");
    cyc(mk(0, 3, 0, 3, 1, 0, 0, 0, BUB), 1, "perf_lu");
    cyc(mk(0, 0, 4, 4, 1, 0, 0, 0, BUB), 1, "perf_lu");
    for (int i = 0; i < 3; i++) cyc(mk(0, 0, 0, 0, 0, 0, 1, 0, FRZ), 1, "perf_wait");
    cyc(mk(0, 0, 0, 0, 0, 0, 1, 1, NRM), 1, "perf_ready");
    #2;
    check("perf_stall_total", 64'(bus.stall_cnt_o), PERF ? 64'd5 : 64'd0);
    check("perf_flush_total", 64'(bus.flush_cnt_o), 64'd0);
    @(negedge clk);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      v = mk(($urandom_range(63) == 0), 5'($urandom_range(3)), 5'($urandom_range(3)),
             5'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
             ($urandom_range(2) != 0), ($urandom_range(3) == 0), 8'h00);
      cyc(v, 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
